// File: rtl/uncrop_pad.sv
// uncrop_pad: re-expands a cropped raster stream into the full frame,
// filling every position outside the crop window with a constant pad.
module uncrop_pad #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS = 40,
  parameter int IN_COLS = 40,
  parameter int OUT_ROWS = 20,
  parameter int OUT_COLS = 20,
  parameter int Y_1 = 10,
  parameter int X_1 = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready
);

  localparam int XW = $clog2(IN_COLS) + 1;
  localparam int YW = $clog2(IN_ROWS) + 1;

  typedef enum logic {
    WAIT = 1'b0,
    GEN  = 1'b1
  } state_t;

  state_t                     state_q;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_q, pixel_d;
  logic                       valid_q, last_q;

  logic gen, in_win, can_load, load;
  logic at_end_x, at_end;

  assign gen = (state_q == GEN);

  // Signed compares keep a window starting at 0 free of constant-compare lint.
  assign in_win = (int'(y_q) >= Y_1) && (int'(y_q) < Y_1 + OUT_ROWS) &&
                  (int'(x_q) >= X_1) && (int'(x_q) < X_1 + OUT_COLS);

  assign can_load = !valid_q || out_ready;
  assign in_ready = gen && in_win && can_load;
  assign load     = gen && can_load && (!in_win || in_valid);

  assign at_end_x = (x_q == XW'(IN_COLS - 1));
  assign at_end   = at_end_x && (y_q == YW'(IN_ROWS - 1));

  assign pixel_d = in_win ? pixel_in : PAD_VALUE;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      if (at_end_x) begin
        x_d = '0;
        y_d = at_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      x_q     <= '0;
      y_q     <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      unique case (state_q)
        WAIT: if (in_valid) state_q <= GEN;
        GEN:  if (load && at_end) state_q <= WAIT;
      endcase
      if (load) begin
        valid_q <= 1'b1;
        pixel_q <= pixel_d;
        last_q  <= at_end;
      end else if (out_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign pixel_out = pixel_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_uncrop_pad.sv
// tb_uncrop_pad: scenario tasks driving two 4x4 uncrop_pad instances
// and comparing against a coordinate-level frame model.
module tb_uncrop_pad;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pixel_in = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  int           sel = 0;

  logic         a_ir, a_ov, a_ol, b_ir, b_ov, b_ol;
  logic [W-1:0] a_po, b_po;
  logic         in_ready, out_valid, out_last;
  logic [W-1:0] pixel_out;

  assign in_ready  = (sel != 0) ? b_ir : a_ir;
  assign out_valid = (sel != 0) ? b_ov : a_ov;
  assign out_last  = (sel != 0) ? b_ol : a_ol;
  assign pixel_out = (sel != 0) ? b_po : a_po;

  uncrop_pad #(
    .PIXEL_BIT_WIDTH(W), .IN_ROWS(4), .IN_COLS(4),
    .OUT_ROWS(2), .OUT_COLS(2), .Y_1(1), .X_1(1), .PAD_VALUE('0)
  ) dut_a (
    .clk(clk), .reset(reset), .pixel_in(pixel_in),
    .in_valid(in_valid), .in_ready(a_ir), .pixel_out(a_po),
    .out_valid(a_ov), .out_last(a_ol), .out_ready(out_ready)
  );

  uncrop_pad #(
    .PIXEL_BIT_WIDTH(W), .IN_ROWS(4), .IN_COLS(4),
    .OUT_ROWS(4), .OUT_COLS(4), .Y_1(0), .X_1(0), .PAD_VALUE('0)
  ) dut_b (
    .clk(clk), .reset(reset), .pixel_in(pixel_in),
    .in_valid(in_valid), .in_ready(b_ir), .pixel_out(b_po),
    .out_valid(b_ov), .out_last(b_ol), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] in_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           glast_q[$];
  int ir_high, ir_out, gaps, first_cyc, stab_bad, accepted;

  function automatic bit inside_k(input int k);
    int x, y;
    x = k % 4;
    y = (k % 16) / 4;
    if (sel != 0) return 1'b1;
    return (y >= 1) && (y < 3) && (x >= 1) && (x < 3);
  endfunction

  function automatic void build_exp(input int nfr);
    int j;
    j = 0;
    exp_q.delete();
    for (int f = 0; f < nfr; f++)
      for (int k = 0; k < 16; k++)
        if (inside_k(k)) begin
          exp_q.push_back(src_q[j]);
          j++;
        end else begin
          exp_q.push_back('0);
        end
  endfunction

  task automatic do_reset(input int s);
    @(negedge clk);
    sel = s;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // or_mode: 0 always ready, 1 toggle, 2 random
  // iv_mode: 0 valid when data, 1 stall 3 cycles on input 3, 2 random
  task automatic run(input int n_out, input int or_mode,
                     input int iv_mode, input int abort_after);
    int cyc, loads, stall;
    bit prev_hold, prev_last;
    logic [W-1:0] prev_pix;
    cyc = 0; stall = 0; prev_hold = 0; prev_last = 0; prev_pix = '0;
    in_q = src_q;
    got_q.delete();
    glast_q.delete();
    ir_high = 0; ir_out = 0; gaps = 0; first_cyc = -1;
    stab_bad = 0; accepted = 0;
    while (got_q.size() < n_out && got_q.size() != abort_after) begin
      @(negedge clk);
      if (cyc >= 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout got %0d outputs want %0d", got_q.size(), n_out);
        break;
      end
      if (prev_hold && (!out_valid || pixel_out !== prev_pix ||
                        out_last !== prev_last))
        stab_bad++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (!out_valid && first_cyc >= 0) gaps++;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(99) < 60);
      endcase
      #1;
      loads = got_q.size() + (out_valid ? 1 : 0);
      if (in_ready) begin
        ir_high++;
        if (!inside_k(loads)) ir_out++;
      end
      if (out_valid && !out_ready && in_ready) stab_bad++;
      in_valid = (in_q.size() > 0);
      if (iv_mode == 1 && in_valid && in_q[0] == 3 && in_ready && stall < 3) begin
        stall++;
        in_valid = 1'b0;
      end
      if (iv_mode == 2 && $urandom_range(99) >= 70) in_valid = 1'b0;
      pixel_in = (in_q.size() > 0) ? in_q[0] : W'($urandom);
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        accepted++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(pixel_out);
        glast_q.push_back(out_last);
      end
      prev_hold = out_valid && !out_ready;
      prev_pix = pixel_out;
      prev_last = out_last;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got v%b l%b r%b want 000", out_valid, out_last, in_ready);
    end
    checks++;
    if (pixel_out !== '0) begin
      errors++;
      $display("FAIL reset_pix got %0h want 0", pixel_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset(0);
    src_q = '{12'd1, 12'd2, 12'd3, 12'd4};
    build_exp(1);
    run(16, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL basic_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
    checks++;
    if (ir_high !== 4 || ir_out !== 0) begin
      errors++;
      $display("FAIL basic_inready got high=%0d outside=%0d want 4/0", ir_high, ir_out);
    end
    checks++;
    if (gaps !== 0 || accepted !== 4) begin
      errors++;
      $display("FAIL basic_flow got gaps=%0d acc=%0d want 0/4", gaps, accepted);
    end
  endtask

  task automatic test_stall();
    do_reset(0);
    src_q = '{12'd1, 12'd2, 12'd3, 12'd4};
    build_exp(1);
    run(16, 0, 1, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL stall_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
    checks++;
    if (gaps !== 3 || ir_out !== 0) begin
      errors++;
      $display("FAIL stall_gaps got gaps=%0d outside=%0d want 3/0", gaps, ir_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset(0);
    src_q = '{12'h5a1, 12'h0f2, 12'h7c3, 12'h3d4};
    build_exp(1);
    run(16, 1, 0, -1);
    checks++;
    if (got_q.size() !== 16) begin
      errors++;
      $display("FAIL bp_count got %0d want 16", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL bp_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
    checks++;
    if (stab_bad !== 0 || ir_out !== 0) begin
      errors++;
      $display("FAIL bp_hold got unstable=%0d outside=%0d want 0/0", stab_bad, ir_out);
    end
  endtask

  task automatic test_corner();
    do_reset(1);
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(W'(i));
    build_exp(1);
    run(16, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL corner_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
    checks++;
    if (ir_high !== 16 || first_cyc !== 2) begin
      errors++;
      $display("FAIL corner_timing got high=%0d first=%0d want 16/2", ir_high, first_cyc);
    end
    sel = 0;
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    src_q = '{12'd1, 12'd2, 12'd3, 12'd4};
    run(16, 0, 0, 6);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctl got v%b l%b r%b want 000", out_valid, out_last, in_ready);
    end
    reset = 1'b0;
    src_q = '{12'h11, 12'h22, 12'h33, 12'h44};
    build_exp(1);
    run(16, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL midreset_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    src_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
    build_exp(2);
    run(32, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL b2b_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
    checks++;
    if (gaps !== 1 || accepted !== 8) begin
      errors++;
      $display("FAIL b2b_bubble got gaps=%0d acc=%0d want 1/8", gaps, accepted);
    end
  endtask

  task automatic test_random();
    do_reset(0);
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(W'($urandom));
    build_exp(3);
    run(48, 2, 2, -1);
    checks++;
    if (got_q.size() !== 48 || in_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count got out=%0d left=%0d want 48/0", got_q.size(), in_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || glast_q[i] != (i % 16 == 15)) begin
        errors++;
        $display("FAIL rand_seq[%0d] got %0h/%b want %0h/%b",
                 i, got_q[i], glast_q[i], exp_q[i], (i % 16 == 15));
      end
    end
    checks++;
    if (stab_bad !== 0 || ir_out !== 0) begin
      errors++;
      $display("FAIL rand_hold got unstable=%0d outside=%0d want 0/0", stab_bad, ir_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_corner();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
